seg7_frame_decoder: RTL and testbench



---
 rtl/seg7_frame_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_seg7_frame_decoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_frame_decoder.sv
// ---------------------------------------------------------------------------
// seg7_frame_decoder
//
// Watches a seven-segment output bus and rebuilds the frames being shown.
// The raw segment lines are double-flopped, then a pattern must stay
// unchanged for STABLE_CYCLES synchronized samples before it is reported
// as a frame. Each frame carries its hex glyph value (when it is one), the
// number of clock cycles since the previous frame, and a running count.
//
// Parameters
//   STABLE_CYCLES : equal synchronized samples needed to accept (>= 2)
//   PERIOD_WIDTH  : width of the frame-period measurement (saturating)
//
// Ports
//   clk           : system clock
//   reset         : asynchronous, active-high; clears all state
//   segments_in   : segment lines, active-high, bit0 = a ... bit6 = g
//   frame_valid   : one-cycle pulse when a new stable pattern is accepted
//   frame_pattern : last accepted pattern, held between frames
//   frame_code    : hex value of frame_pattern when it is a glyph, else 0
//   code_valid    : frame_pattern is one of the 16 hex glyphs
//   frame_period  : cycles between the last two frame_valid pulses
//   period_valid  : frame_period holds a real measurement
//   frame_count   : accepted frames since reset, wraps 255 -> 0
// ---------------------------------------------------------------------------
module seg7_frame_decoder #(
   parameter int unsigned STABLE_CYCLES = 512,
   parameter int unsigned PERIOD_WIDTH  = 24
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [6:0]              segments_in,
   output logic                    frame_valid,
   output logic [6:0]              frame_pattern,
   output logic [3:0]              frame_code,
   output logic                    code_valid,
   output logic [PERIOD_WIDTH-1:0] frame_period,
   output logic                    period_valid,
   output logic [7:0]              frame_count
);

   localparam int unsigned CNT_W  = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
   localparam int unsigned PINC_W = PERIOD_WIDTH + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   // have_frame is encoded as (state != ST_EMPTY)
   typedef enum logic [1:0] {
      ST_EMPTY    = 2'd0,
      ST_SETTLING = 2'd1,
      ST_LOCKED   = 2'd2
   } state_t;

   // Registers
   state_t                  r_state;
   logic [6:0]              r_s1;
   logic [6:0]              r_s2;
   logic [6:0]              r_cand;
   logic [CNT_W-1:0]        r_cnt;
   logic [PERIOD_WIDTH-1:0] r_pcnt;
   logic                    r_frame_valid;
   logic [6:0]              r_acc;
   logic [3:0]              r_frame_code;
   logic                    r_code_valid;
   logic [PERIOD_WIDTH-1:0] r_frame_period;
   logic                    r_period_valid;
   logic [7:0]              r_frame_count;

   // Next-state values
   state_t                  w_state_nxt;
   logic [6:0]              w_cand_nxt;
   logic [CNT_W-1:0]        w_cnt_nxt;
   logic [PERIOD_WIDTH-1:0] w_pcnt_nxt;
   logic                    w_frame_valid_nxt;
   logic [6:0]              w_acc_nxt;
   logic [3:0]              w_frame_code_nxt;
   logic                    w_code_valid_nxt;
   logic [PERIOD_WIDTH-1:0] w_frame_period_nxt;
   logic                    w_period_valid_nxt;
   logic [7:0]              w_frame_count_nxt;

   logic                    w_accept;
   logic [3:0]              w_glyph_code;
   logic                    w_glyph_valid;
   logic [PINC_W-1:0]       w_pcnt_inc;
   logic [PERIOD_WIDTH-1:0] w_period_sat;

   // Glyph lookup of the candidate pattern (a = bit0)
   always_comb begin
      w_glyph_code  = 4'h0;
      w_glyph_valid = 1'b1;
      case (r_cand)
         7'h3F:   w_glyph_code = 4'h0;
         7'h06:   w_glyph_code = 4'h1;
         7'h5B:   w_glyph_code = 4'h2;
         7'h4F:   w_glyph_code = 4'h3;
         7'h66:   w_glyph_code = 4'h4;
         7'h6D:   w_glyph_code = 4'h5;
         7'h7D:   w_glyph_code = 4'h6;
         7'h07:   w_glyph_code = 4'h7;
         7'h7F:   w_glyph_code = 4'h8;
         7'h6F:   w_glyph_code = 4'h9;
         7'h77:   w_glyph_code = 4'hA;
         7'h7C:   w_glyph_code = 4'hB;
         7'h39:   w_glyph_code = 4'hC;
         7'h5E:   w_glyph_code = 4'hD;
         7'h79:   w_glyph_code = 4'hE;
         7'h71:   w_glyph_code = 4'hF;
         default: w_glyph_valid = 1'b0;
      endcase
   end

   // Period measured as pcnt+1, clipped to all-ones
   always_comb begin
      w_pcnt_inc   = {1'b0, r_pcnt} + PINC_W'(1);
      w_period_sat = w_pcnt_inc[PERIOD_WIDTH] ? {PERIOD_WIDTH{1'b1}}
                                              : w_pcnt_inc[PERIOD_WIDTH-1:0];
   end

   // Settle logic, FSM next state and frame outputs
   always_comb begin
      w_state_nxt        = r_state;
      w_cand_nxt         = r_cand;
      w_cnt_nxt          = r_cnt;
      w_pcnt_nxt         = (r_pcnt == {PERIOD_WIDTH{1'b1}}) ? r_pcnt
                                                           : r_pcnt + PERIOD_WIDTH'(1);
      w_frame_valid_nxt  = 1'b0;
      w_acc_nxt          = r_acc;
      w_frame_code_nxt   = r_frame_code;
      w_code_valid_nxt   = r_code_valid;
      w_frame_period_nxt = r_frame_period;
      w_period_valid_nxt = r_period_valid;
      w_frame_count_nxt  = r_frame_count;
      w_accept           = 1'b0;

      // Any change restarts the count from the new value
      if (r_s2 != r_cand) begin
         w_cand_nxt = r_s2;
         w_cnt_nxt  = '0;
      end else if (r_cnt != CNT_MAX) begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end else if ((r_state == ST_EMPTY) || (r_cand != r_acc)) begin
         w_accept = 1'b1;
      end

      if (w_accept) begin
         w_acc_nxt         = r_cand;
         w_frame_code_nxt  = w_glyph_code;
         w_code_valid_nxt  = w_glyph_valid;
         w_frame_valid_nxt = 1'b1;
         w_frame_count_nxt = r_frame_count + 8'd1;
         w_pcnt_nxt        = '0;
         // First frame after reset has no predecessor to measure against
         if (r_state != ST_EMPTY) begin
            w_frame_period_nxt = w_period_sat;
            w_period_valid_nxt = 1'b1;
         end
      end

      // Returning to the accepted pattern relocks silently
      if (w_accept) begin
         w_state_nxt = ST_LOCKED;
      end else if (r_state == ST_EMPTY) begin
         w_state_nxt = ST_EMPTY;
      end else if ((w_cand_nxt == r_acc) && (w_cnt_nxt == CNT_MAX)) begin
         w_state_nxt = ST_LOCKED;
      end else begin
         w_state_nxt = ST_SETTLING;
      end
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= ST_EMPTY;
         r_s1           <= '0;
         r_s2           <= '0;
         r_cand         <= '0;
         r_cnt          <= '0;
         r_pcnt         <= '0;
         r_frame_valid  <= 1'b0;
         r_acc          <= '0;
         r_frame_code   <= '0;
         r_code_valid   <= 1'b0;
         r_frame_period <= '0;
         r_period_valid <= 1'b0;
         r_frame_count  <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_s1           <= segments_in;
         r_s2           <= r_s1;
         r_cand         <= w_cand_nxt;
         r_cnt          <= w_cnt_nxt;
         r_pcnt         <= w_pcnt_nxt;
         r_frame_valid  <= w_frame_valid_nxt;
         r_acc          <= w_acc_nxt;
         r_frame_code   <= w_frame_code_nxt;
         r_code_valid   <= w_code_valid_nxt;
         r_frame_period <= w_frame_period_nxt;
         r_period_valid <= w_period_valid_nxt;
         r_frame_count  <= w_frame_count_nxt;
      end
   end

   assign frame_valid   = r_frame_valid;
   assign frame_pattern = r_acc;
   assign frame_code    = r_frame_code;
   assign code_valid    = r_code_valid;
   assign frame_period  = r_frame_period;
   assign period_valid  = r_period_valid;
   assign frame_count   = r_frame_count;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg7_frame_decoder
//
// Directed bench for seg7_frame_decoder with STABLE_CYCLES=4, PERIOD_WIDTH=8.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point, i.e. after edge Ek has settled.
// ---------------------------------------------------------------------------
module tb_seg7_frame_decoder;

   localparam int unsigned STABLE_CYCLES = 4;
   localparam int unsigned PERIOD_WIDTH  = 8;

   localparam logic [6:0] GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic                    clk = 1'b0;
   logic                    reset;
   logic [6:0]              segments_in;
   logic                    frame_valid;
   logic [6:0]              frame_pattern;
   logic [3:0]              frame_code;
   logic                    code_valid;
   logic [PERIOD_WIDTH-1:0] frame_period;
   logic                    period_valid;
   logic [7:0]              frame_count;

   int n_checks = 0;
   int n_fail   = 0;

   seg7_frame_decoder #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .PERIOD_WIDTH  (PERIOD_WIDTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .segments_in   (segments_in),
      .frame_valid   (frame_valid),
      .frame_pattern (frame_pattern),
      .frame_code    (frame_code),
      .code_valid    (code_valid),
      .frame_period  (frame_period),
      .period_valid  (period_valid),
      .frame_count   (frame_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [22:0] obs;
      reset       = 1'b1;
      segments_in = 7'h3F;
      repeat (3) tick();
      obs = {frame_valid, frame_pattern, frame_code, code_valid, frame_period,
             period_valid, frame_count[0]};
      n_checks++;
      if ({obs, frame_count[7:1]} !== 30'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required 0", {obs, frame_count[7:1]});
      end
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         n_checks++;
         if (frame_valid !== (k == 6)) begin
            n_fail++;
            $display("FAIL first_frame_pulse E%0d: got %b required %b", k, frame_valid, (k == 6));
         end
         if (k == 6) begin
            n_checks++;
            if ({frame_pattern, frame_code, code_valid, frame_count, period_valid, frame_period}
                !== {7'h3F, 4'h0, 1'b1, 8'd1, 1'b0, 8'd0}) begin
               n_fail++;
               $display("FAIL first_frame_fields: got pat=%h code=%h cv=%b cnt=%0d pv=%b per=%0d required pat=3f code=0 cv=1 cnt=1 pv=0 per=0",
                        frame_pattern, frame_code, code_valid, frame_count, period_valid, frame_period);
            end
         end
      end
   endtask

   task automatic test_glitch();
      int pulses = 0;
      segments_in = 7'h06;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (frame_valid) pulses++;
      end
      segments_in = 7'h3F;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (frame_valid) pulses++;
      end
      n_checks++;
      if (pulses !== 0) begin
         n_fail++;
         $display("FAIL glitch_pulses: got %0d required 0", pulses);
      end
      n_checks++;
      if ({frame_pattern, frame_code, code_valid, frame_count, period_valid}
          !== {7'h3F, 4'h0, 1'b1, 8'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL glitch_hold: got pat=%h code=%h cv=%b cnt=%0d pv=%b required pat=3f code=0 cv=1 cnt=1 pv=0",
                  frame_pattern, frame_code, code_valid, frame_count, period_valid);
      end
   endtask

   task automatic test_period();
      segments_in = 7'h06;
      for (int k = 0; k < 28; k++) begin
         tick();
         if (k == 19) segments_in = 7'h5B;
         n_checks++;
         if (frame_valid !== (k == 6 || k == 26)) begin
            n_fail++;
            $display("FAIL period_pulse E%0d: got %b required %b", k, frame_valid, (k == 6 || k == 26));
         end
         if (k == 6) begin
            n_checks++;
            if ({frame_pattern, frame_code, code_valid, frame_count, period_valid}
                !== {7'h06, 4'h1, 1'b1, 8'd2, 1'b1}) begin
               n_fail++;
               $display("FAIL period_frame_06: got pat=%h code=%h cv=%b cnt=%0d pv=%b required pat=06 code=1 cv=1 cnt=2 pv=1",
                        frame_pattern, frame_code, code_valid, frame_count, period_valid);
            end
         end
         if (k == 26) begin
            n_checks++;
            if ({frame_pattern, frame_code, code_valid, frame_count, period_valid, frame_period}
                !== {7'h5B, 4'h2, 1'b1, 8'd3, 1'b1, 8'd20}) begin
               n_fail++;
               $display("FAIL period_frame_5b: got pat=%h code=%h cv=%b cnt=%0d pv=%b per=%0d required pat=5b code=2 cv=1 cnt=3 pv=1 per=20",
                        frame_pattern, frame_code, code_valid, frame_count, period_valid, frame_period);
            end
         end
      end
   endtask

   task automatic test_non_glyph();
      segments_in = 7'h49;
      for (int k = 0; k < 8; k++) begin
         tick();
         n_checks++;
         if (frame_valid !== (k == 6)) begin
            n_fail++;
            $display("FAIL non_glyph_pulse E%0d: got %b required %b", k, frame_valid, (k == 6));
         end
         if (k == 6) begin
            n_checks++;
            if ({frame_pattern, frame_code, code_valid, frame_count, frame_period}
                !== {7'h49, 4'h0, 1'b0, 8'd4, 8'd8}) begin
               n_fail++;
               $display("FAIL non_glyph_fields: got pat=%h code=%h cv=%b cnt=%0d per=%0d required pat=49 code=0 cv=0 cnt=4 per=8",
                        frame_pattern, frame_code, code_valid, frame_count, frame_period);
            end
         end
      end
   endtask

   task automatic test_saturation();
      int pulses = 0;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (frame_valid) pulses++;
      end
      n_checks++;
      if (pulses !== 0) begin
         n_fail++;
         $display("FAIL hold_pulses: got %0d required 0", pulses);
      end
      segments_in = 7'h3F;
      for (int k = 0; k < 8; k++) begin
         tick();
         n_checks++;
         if (frame_valid !== (k == 6)) begin
            n_fail++;
            $display("FAIL sat_pulse E%0d: got %b required %b", k, frame_valid, (k == 6));
         end
         if (k == 6) begin
            n_checks++;
            if ({frame_period, period_valid, frame_count, frame_code, code_valid}
                !== {8'd255, 1'b1, 8'd5, 4'h0, 1'b1}) begin
               n_fail++;
               $display("FAIL sat_fields: got per=%0d pv=%b cnt=%0d code=%h cv=%b required per=255 pv=1 cnt=5 code=0 cv=1",
                        frame_period, period_valid, frame_count, frame_code, code_valid);
            end
         end
      end
   endtask

   task automatic test_all_glyphs();
      for (int j = 0; j < 16; j++) begin
         int idx = (j + 1) % 16;
         segments_in = GLYPH[idx];
         for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if (frame_valid !== (k == 6)) begin
               n_fail++;
               $display("FAIL glyph_%0d_pulse E%0d: got %b required %b", idx, k, frame_valid, (k == 6));
            end
            if (k == 6) begin
               n_checks++;
               if ({frame_pattern, frame_code, code_valid, frame_period}
                   !== {GLYPH[idx], 4'(idx), 1'b1, 8'd8}) begin
                  n_fail++;
                  $display("FAIL glyph_%0d_fields: got pat=%h code=%h cv=%b per=%0d required pat=%h code=%h cv=1 per=8",
                           idx, frame_pattern, frame_code, code_valid, frame_period, GLYPH[idx], 4'(idx));
               end
            end
         end
      end
      n_checks++;
      if (frame_count !== 8'd21) begin
         n_fail++;
         $display("FAIL glyph_count: got %0d required 21", frame_count);
      end
   endtask

   task automatic test_reset_mid_settle();
      segments_in = 7'h06;
      repeat (3) tick();
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({frame_valid, frame_pattern, frame_code, code_valid, frame_period, period_valid, frame_count}
          !== 30'd0) begin
         n_fail++;
         $display("FAIL async_reset: got %h required 0",
                  {frame_valid, frame_pattern, frame_code, code_valid, frame_period, period_valid, frame_count});
      end
      repeat (2) tick();
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         n_checks++;
         if (frame_valid !== (k == 6)) begin
            n_fail++;
            $display("FAIL rereport_pulse E%0d: got %b required %b", k, frame_valid, (k == 6));
         end
         if (k == 6) begin
            n_checks++;
            if ({frame_pattern, frame_code, code_valid, frame_count, period_valid, frame_period}
                !== {7'h06, 4'h1, 1'b1, 8'd1, 1'b0, 8'd0}) begin
               n_fail++;
               $display("FAIL rereport_fields: got pat=%h code=%h cv=%b cnt=%0d pv=%b per=%0d required pat=06 code=1 cv=1 cnt=1 pv=0 per=0",
                        frame_pattern, frame_code, code_valid, frame_count, period_valid, frame_period);
            end
         end
      end
   endtask

   initial begin
      reset       = 1'b1;
      segments_in = 7'h00;
      test_reset();
      test_glitch();
      test_period();
      test_non_glyph();
      test_saturation();
      test_all_glyphs();
      test_reset_mid_settle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
